prog_counter_n: RTL
===================

PROG_COUNTER_N -- requirements
Module: prog_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter/limit/data width in bits (legal 2..32).
REQ-002 The block SHALL have parameter LIMIT_RST, default all-ones of WIDTH, reset value of the limit register.
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port clear  input  1  synchronous clear of count and done.
REQ-006 The block SHALL have port load  input  1  synchronous load of data_in into count.
REQ-007 The block SHALL have port data_in  input  WIDTH  load value.
REQ-008 The block SHALL have port en  input  1  count enable.
REQ-009 The block SHALL have port dir  input  1  count direction (1 = up, 0 = down).
REQ-010 The block SHALL have port oneshot  input  1  mode (1 = stop at terminal, 0 = wrap).
REQ-011 The block SHALL have port limit_we  input  1  write enable for the limit register.
REQ-012 The block SHALL have port limit_in  input  WIDTH  new limit value.
REQ-013 The block SHALL have port out_en  input  1  tri-state output enable.
REQ-014 The block SHALL have port data_out  output  WIDTH  count when out_en=1, high-impedance otherwise.
REQ-015 The block SHALL have port count  output  WIDTH  count, always driven.
REQ-016 The block SHALL have port tc  output  1  registered terminal-count pulse.
REQ-017 The block SHALL have port done  output  1  one-shot completion flag.

Function
REQ-018 Count update priority SHALL be: clear (count to 0, done to 0) > load (count to data_in, done to 0) > count step > hold.
REQ-019 A count step SHALL occur only when en=1 and done=0.
REQ-020 Up terminal condition SHALL be count >= limit; a count below limit steps to count+1.
REQ-021 Down terminal condition SHALL be count == 0; a count above 0 steps to count-1.
REQ-022 At a terminal step with oneshot=0, up SHALL wrap count to 0 and down SHALL reload count to limit.
REQ-023 At a terminal step with oneshot=1, count SHALL hold and done SHALL set to 1 on the same edge.
REQ-024 tc SHALL be 1 for exactly the one cycle following each terminal step in either mode, and 0 otherwise.
REQ-025 With done=1, tc SHALL stay 0 and count SHALL hold until clear or load.
REQ-026 The limit register SHALL update on limit_we independently of the count path.
REQ-027 A count step in the same cycle as limit_we SHALL compare against the old limit value.
REQ-028 dir and oneshot SHALL be sampled every cycle, so a change takes effect on the next step without restarting the count.
REQ-029 A load or clear coincident with a terminal condition SHALL win, so tc is not asserted.
REQ-030 Arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-031 limit = 0 SHALL make every enabled up step terminal (count stays 0 and tc pulses each step in wrap mode).
REQ-032 data_out SHALL be combinational from count and out_en, with no extra latency; count changes appear on data_out the cycle after the edge.

Reset
REQ-033 rst_n=0 SHALL immediately force count=0, limit=LIMIT_RST, tc=0 and done=0, regardless of clk.
REQ-034 Reset deassertion SHALL take effect on the next rising clk, and no step SHALL be lost or doubled on that edge.
REQ-035 data_out SHALL follow out_en during reset (0 if out_en=1, Z if out_en=0).

Verification
REQ-036 WIDTH=8, limit=5, up, wrap, en=1 from 0 -> count 0,1,2,3,4,5,0,1; tc high only in the cycle after count=5.
REQ-037 WIDTH=8, limit=3, down, oneshot=1, load 3 then en=1 -> count 3,2,1,0,0; done=1 and one tc pulse; then load 2 -> done=0 and counting resumes.
REQ-038 Load 200 with limit=100, up, wrap -> next step gives count=0 and tc pulse.
REQ-039 clear, load and en all high with count=5 -> count=0; then load+en with data_in=9 -> count=9; then limit_we with limit=9 and a step at count=9 -> old limit used and count=10.
REQ-040 out_en toggling -> data_out alternates between count and all-Z; count port unaffected.
REQ-041 rst_n pulsed low mid-count (count=7, limit=20) asynchronously -> count=0, limit=all-ones, done=0 and tc=0 before the next clk edge.

Source files
------------

// File: rtl/prog_counter_n.sv
// prog_counter_n: programmable up/down counter with a writable limit register,
// wrap or one-shot terminal behaviour, a registered terminal-count pulse and a
// tri-state copy of the count.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   clear, load       synchronous clear / load of the count (clear wins)
//   data_in           load value
//   en, dir, oneshot  step enable, direction (1 = up), stop-at-terminal mode
//   limit_we/limit_in limit register write port
//   out_en            enables the data_out drivers
//   data_out          count when out_en=1, high-impedance otherwise
//   count             count, always driven
//   tc                one-cycle pulse after each terminal step
//   done              set by a one-shot terminal step, cleared by clear/load
module prog_counter_n #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] LIMIT_RST = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             en,
   input  logic             dir,
   input  logic             oneshot,
   input  logic             limit_we,
   input  logic [WIDTH-1:0] limit_in,
   input  logic             out_en,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             step_c;
   logic             at_term_c;

   // A step is only possible while enabled and not parked in one-shot done.
   assign step_c    = en && !done_q;
   // Terminal test uses the registered limit, so a same-cycle write is not seen.
   assign at_term_c = dir ? (count_q >= limit_q) : (count_q == CNT_ZERO);

   // Next-state logic for count, done and the terminal pulse.
   always_comb begin
      count_d = count_q;
      done_d  = done_q;
      tc_d    = 1'b0;
      if (clear) begin
         count_d = CNT_ZERO;
         done_d  = 1'b0;
      end else if (load) begin
         count_d = data_in;
         done_d  = 1'b0;
      end else if (step_c) begin
         if (!at_term_c) begin
            count_d = dir ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
         end else begin
            tc_d = 1'b1;
            if (oneshot) begin
               done_d = 1'b1;
            end else begin
               count_d = dir ? CNT_ZERO : limit_q;
            end
         end
      end
   end

   // Limit register is written independently of the count path.
   assign limit_d = limit_we ? limit_in : limit_q;

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= CNT_ZERO;
         limit_q <= LIMIT_RST;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         limit_q <= limit_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign done     = done_q;
   assign data_out = out_en ? count_q : {WIDTH{1'bz}};

endmodule
